// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 4-op ALU (add/sub/AND/OR).
// Response is registered and held under valid/ready backpressure.
module alu_rr_arbiter #(
  parameter int NB_size = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req0_valid,
  input  logic [1:0]         i_req0_sel,
  input  logic [NB_size-1:0] i_req0_dataA,
  input  logic [NB_size-1:0] i_req0_dataB,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [1:0]         i_req1_sel,
  input  logic [NB_size-1:0] i_req1_dataA,
  input  logic [NB_size-1:0] i_req1_dataB,
  output logic               o_req1_ready,
  output logic               o_rsp_valid,
  output logic               o_rsp_id,
  output logic [NB_size-1:0] o_rsp_data,
  output logic               o_rsp_carry,
  input  logic               i_rsp_ready,
  output logic [15:0]        o_ops_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [1:0]           sel_q, sel_d;
  logic [NB_size-1:0]   a_q, a_d;
  logic [NB_size-1:0]   b_q, b_d;
  logic                 id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [NB_size-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic [15:0]          ops_count_q, ops_count_d;

  logic                 grant0, grant1;
  logic [NB_size:0]     alu_wide;

  // Grants only exist in IDLE; prio breaks ties when both requesters are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (i_req0_valid && i_req1_valid) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = i_req0_valid;
        grant1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // Extra top bit carries the unsigned carry-out / borrow for add and sub.
  always_comb begin
    case (sel_q)
      2'b00:   alu_wide = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   alu_wide = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   alu_wide = {1'b0, a_q & b_q};
      default: alu_wide = {1'b0, a_q | b_q};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    ops_count_d = ops_count_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          sel_d   = grant1 ? i_req1_sel   : i_req0_sel;
          a_d     = grant1 ? i_req1_dataA : i_req0_dataA;
          b_d     = grant1 ? i_req1_dataB : i_req0_dataB;
          id_d    = grant1;
          prio_d  = grant0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_wide[NB_size-1:0];
        rsp_carry_d = alu_wide[NB_size];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_count_d = ops_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      ops_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_carry = rsp_carry_q;
  assign o_ops_count = ops_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [1:0]  s0, s1;
  logic [15:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_ready;
  logic [15:0] rsp_data, ops_count;

  alu_rr_arbiter #(.NB_size(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_sel(s0), .i_req0_dataA(a0), .i_req0_dataB(b0),
    .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_sel(s1), .i_req1_dataA(a1), .i_req1_dataB(b1),
    .o_req1_ready(r1),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .o_rsp_carry(rsp_carry), .i_rsp_ready(rsp_ready), .o_ops_count(ops_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: one outstanding transaction, response due two edges after accept.
  bit          m_busy;
  int          m_wait;
  bit          m_prio;
  int unsigned m_count;
  bit          m_id;
  logic [15:0] m_data;
  bit          m_carry;

  bit          got_rsp;
  logic        got_id, got_carry;
  logic [15:0] got_data;

  typedef struct {
    bit          v0, v1;
    logic [1:0]  s0, s1;
    logic [15:0] a0, b0, a1, b1;
    bit          e_id;
    logic [15:0] e_data;
    bit          e_carry;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_prio = 0; m_count = 0;
    m_id = 0; m_data = '0; m_carry = 0;
  endtask

  task automatic model_load(input bit id, input logic [1:0] sel,
                            input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, r;
    ua = a; ub = b;
    m_id = id;
    case (sel)
      2'd0: begin r = ua + ub; m_data = r[15:0]; m_carry = (r > 65535); end
      2'd1: begin r = ua - ub; m_data = r[15:0]; m_carry = (ua < ub); end
      2'd2: begin m_data = a & b; m_carry = 0; end
      default: begin m_data = a | b; m_carry = 0; end
    endcase
  endtask

  // Called just after a negedge with inputs set; checks then advances one clock.
  task automatic cycle();
    bit g0, g1, ev;
    #1;
    g0 = 0; g1 = 0;
    if (!m_busy) begin
      if (v0 && v1) begin g0 = (m_prio == 0); g1 = (m_prio == 1); end
      else begin g0 = v0; g1 = v1; end
    end
    ev = m_busy && (m_wait == 0);
    check("ready0", {31'd0, r0}, {31'd0, g0});
    check("ready1", {31'd0, r1}, {31'd0, g1});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    check("ops_count", {16'd0, ops_count}, m_count);
    if (ev) begin
      check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      check("rsp_data", {16'd0, rsp_data}, {16'd0, m_data});
      check("rsp_carry", {31'd0, rsp_carry}, {31'd0, m_carry});
    end
    if (rsp_valid && rsp_ready) begin
      got_rsp = 1; got_id = rsp_id; got_data = rsp_data; got_carry = rsp_carry;
    end
    if (m_busy) begin
      if (m_wait > 0) m_wait--;
      else if (rsp_ready) begin m_busy = 0; m_count = (m_count + 1) % 65536; end
    end else if (g0 || g1) begin
      if (g1) model_load(1, s1, a1, b1);
      else    model_load(0, s0, a0, b0);
      m_busy = 1; m_wait = 1; m_prio = g0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, {31'd0, r0}, 32'd0);
    check({tag, "_ready1"}, {31'd0, r1}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
    check({tag, "_rsp_carry"}, {31'd0, rsp_carry}, 32'd0);
    check({tag, "_ops_count"}, {16'd0, ops_count}, 32'd0);
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; s0 = '0; s1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  // Runs until a response is consumed or the budget expires.
  task automatic run_until_rsp(input string nm, input int budget);
    int n;
    got_rsp = 0;
    n = 0;
    while (!got_rsp && n < budget) begin cycle(); n++; end
    check({nm, "_timeout"}, {31'd0, got_rsp}, 32'd1);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1,0, 2'd0,2'd0, 16'h7FFF,16'h0001, 16'h0,16'h0,       0, 16'h8000, 0};
    tbl[1] = '{0,1, 2'd0,2'd1, 16'h0,16'h0, 16'h0003,16'h0005,       1, 16'hFFFE, 1};
    tbl[2] = '{0,1, 2'd0,2'd0, 16'h0,16'h0, 16'hFFFF,16'h0001,       1, 16'h0000, 1};
    tbl[3] = '{1,1, 2'd2,2'd3, 16'hF0F0,16'h3C3C, 16'hF0F0,16'h3C3C, 0, 16'h3030, 0};
    tbl[4] = '{1,1, 2'd2,2'd3, 16'hF0F0,16'h3C3C, 16'hF0F0,16'h3C3C, 1, 16'hFCFC, 0};
    tbl[5] = '{1,1, 2'd2,2'd3, 16'hF0F0,16'h3C3C, 16'hF0F0,16'h3C3C, 0, 16'h3030, 0};
    tbl[6] = '{1,1, 2'd2,2'd3, 16'hF0F0,16'h3C3C, 16'hF0F0,16'h3C3C, 1, 16'hFCFC, 0};

    idle_inputs();
    rsp_ready = 0;
    rst = 1;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_reset_outputs("idle10");

    // Directed table with the consumer always ready.
    rsp_ready = 1;
    for (int i = 0; i < 7; i++) begin
      v0 = tbl[i].v0; v1 = tbl[i].v1;
      s0 = tbl[i].s0; a0 = tbl[i].a0; b0 = tbl[i].b0;
      s1 = tbl[i].s1; a1 = tbl[i].a1; b1 = tbl[i].b1;
      run_until_rsp($sformatf("vec%0d", i), 8);
      check($sformatf("vec%0d_id", i), {31'd0, got_id}, {31'd0, tbl[i].e_id});
      check($sformatf("vec%0d_data", i), {16'd0, got_data}, {16'd0, tbl[i].e_data});
      check($sformatf("vec%0d_carry", i), {31'd0, got_carry}, {31'd0, tbl[i].e_carry});
    end
    idle_inputs();
    cycle();

    // Backpressure: response held for 5 cycles, requesters keep pushing.
    rsp_ready = 0;
    v0 = 1; s0 = 2'd1; a0 = 16'h1234; b0 = 16'h4321;
    v1 = 1; s1 = 2'd0; a1 = 16'hAAAA; b1 = 16'h5555;
    for (int i = 0; i < 3; i++) cycle();
    check("bp_valid_up", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    check("bp_data_held", {16'd0, rsp_data}, 32'h0000CF13);
    check("bp_carry_held", {31'd0, rsp_carry}, 32'd1);
    rsp_ready = 1;
    v0 = 0;
    cycle();
    rsp_ready = 0;
    cycle();
    cycle();
    cycle();
    check("bp_then_req1", {31'd0, rsp_id}, 32'd1);
    rsp_ready = 1;
    v1 = 0;
    cycle();

    // Reset while a response is pending; prio had been pointed at requester 1.
    rsp_ready = 0;
    v0 = 1; s0 = 2'd0; a0 = 16'h0001; b0 = 16'h0001;
    cycle();
    v0 = 0;
    cycle();
    check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 0;
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) cycle();
    v0 = 1; v1 = 1; s0 = 2'd3; a0 = 16'h00F0; b0 = 16'h000F;
    s1 = 2'd2; a1 = 16'hFFFF; b1 = 16'h0000;
    run_until_rsp("post_rst", 8);
    check("post_rst_prio_id", {31'd0, got_id}, 32'd0);
    check("post_rst_data", {16'd0, got_data}, 32'h000000FF);
    idle_inputs();
    cycle();

    // Counter wrap: preload the counter to its top value, then one operation.
    dut.ops_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    #1;
    check("preset_count", {16'd0, ops_count}, 32'h0000FFFF);
    v1 = 1; s1 = 2'd0; a1 = 16'h0002; b1 = 16'h0003;
    run_until_rsp("wrap", 8);
    v1 = 0;
    cycle();
    check("wrap_count", {16'd0, ops_count}, 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v0 = ($urandom_range(0, 99) < 50);
      v1 = ($urandom_range(0, 99) < 50);
      s0 = 2'($urandom); s1 = 2'($urandom);
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 60);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Shares one 4-operation ALU (add, subtract, AND, OR, with carry/borrow flag) between two independent requesters. Each requester uses a valid/ready handshake. The block arbitrates round-robin, captures the winner's operands, and executes one operation. It returns the registered result, flag and requester ID on a single response port with valid/ready backpressure. It sits between the two datapath clients and the ALU, and is the only path through which either client reaches the ALU.

## Interface
- NB_size, 16, operand/result width in bits (≥2)
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_req0_valid  in  1  requester 0 has an operation pending
- i_req0_sel  in  2  requester 0 opcode: 00 add, 01 sub, 10 AND, 11 OR
- i_req0_dataA  in  NB_size  requester 0 operand A (signed)
- i_req0_dataB  in  NB_size  requester 0 operand B (signed)
- o_req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- i_req1_valid, i_req1_sel, i_req1_dataA, i_req1_dataB, o_req1_ready: same as requester 0, for requester 1
- o_rsp_valid  out  1  response available
- o_rsp_id  out  1  requester that issued the operation
- o_rsp_data  out  NB_size  ALU result
- o_rsp_carry  out  1  carry (add) / borrow (sub); 0 for AND/OR
- i_rsp_ready  in  1  consumer accepts response
- o_ops_count  out  16  completed responses, wraps at 65535→0

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE:
  - Grant logic is combinational from valids and the priority pointer `prio`.
  - Only one valid: grant it. Both valid: grant `prio`. None valid: no grant.
  - o_reqN_ready = (state==IDLE) & grantN; at most one ready high per cycle.
  - On handshake: latch sel, dataA, dataB and ID into operand registers; set `prio` = other requester; go to EXEC.
- EXEC:
  - ALU computes from the operand registers.
  - Register the result into o_rsp_data / o_rsp_carry / o_rsp_id; set o_rsp_valid=1; go to RESP.
- RESP:
  - Hold all response outputs stable until i_rsp_ready=1.
  - On that cycle: o_rsp_valid←0, o_ops_count+1, go to IDLE.
- Arithmetic (A, B are NB_size bits):
  - add: data = (A+B) mod 2^NB; carry = bit NB of {0,A}+{0,B} (unsigned carry-out).
  - sub: data = (A−B) mod 2^NB; carry = bit NB of {0,A}−{0,B}, i.e. 1 iff A<B unsigned.
  - AND/OR: bitwise; carry=0.
  - No signed-overflow flag.
- Requester-side inputs are ignored outside IDLE. A requester deasserting valid before its handshake is legal and loses nothing.
- `prio` changes only on a handshake. A lone requester never changes fairness for the next contention beyond pointing at the other requester.

## Timing
- Reset values: o_req0_ready=0, o_req1_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_carry=0, o_ops_count=0, prio=0, state=IDLE.
- Reset asserted mid-operation (EXEC or RESP) discards the operation; no response is ever produced for it.
- Latency: handshake in cycle T → o_rsp_valid high from cycle T+2.
- Minimum issue interval is 3 cycles: handshake T, response accepted at T+2 with i_rsp_ready=1, next handshake possible at T+3.
- ready is combinational from valid in IDLE (valid→ready path). ready never depends on i_rsp_ready.
- i_rsp_ready held high before o_rsp_valid rises: the response is consumed in its first valid cycle.
- o_ops_count increments exactly on o_rsp_valid & i_rsp_ready. 0xFFFF wraps to 0x0000.

## Test plan
- Reset release, both valids low for 10 cycles → all outputs 0, state stays IDLE, no ready pulses.
- Req0 only: sel=00, A=0x7FFF, B=0x0001, i_rsp_ready=1 → ready0 at T; at T+2 rsp_valid=1, data=0x8000, carry=0, id=0; ops_count=1.
- Req1 only: sel=01, A=0x0003, B=0x0005 → data=0xFFFE, carry=1, id=1. Then sel=00, A=0xFFFF, B=0x0001 → data=0x0000, carry=1.
- Both valid continuously with the consumer always ready:
  - Grants alternate 0,1,0,1 starting with 0.
  - Req0 sel=10, A=0xF0F0, B=0x3C3C → 0x3030, carry=0.
  - Req1 sel=11, same operands → 0xFCFC, carry=0.
- Backpressure: i_rsp_ready=0 for 5 cycles after rsp_valid → data/id/carry stable, both readies low, ops_count unchanged. Then ready=1 for one cycle → returns to IDLE.
- Reset pulse in RESP with rsp_valid=1 → all outputs 0 immediately (asynchronous), prio=0, no response after release. Preset ops_count=0xFFFF (after 65535 ops) then one op → 0x0000.
